// File: rtl/spi_slave.sv
// SPI slave shift engine: oversamples sclk/mosi/ss_n on clk and supports all four CPOL/CPHA modes.
// Received bytes come out with a one-cycle rx_valid pulse; replies come from a loadable tx buffer.
module spi_slave #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  ss_n_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_we_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  sclk_sync_q;
  logic [SYNC_STAGES-1:0]  mosi_sync_q;
  logic [SYNC_STAGES-1:0]  ss_sync_q;
  logic                    sclk_prev_q;
  logic                    ss_prev_q;
  logic                    cpol_l_q;
  logic                    cpha_l_q;
  logic                    first_lead_q;
  logic                    byte_done_q;
  logic [CntW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0]   tx_sr_q;
  logic [DATA_WIDTH-1:0]   rx_sr_q;
  logic [DATA_WIDTH-1:0]   tx_buf_q;
  logic [DATA_WIDTH-1:0]   rx_data_q;
  logic                    rx_valid_q;

  logic                    sclk_s;
  logic                    mosi_s;
  logic                    ss_s;
  logic                    ss_fall;
  logic                    ss_rise;
  logic                    lead_edge;
  logic                    trail_edge;
  logic                    sample_edge;
  logic                    shift_edge;
  logic [DATA_WIDTH-1:0]   rx_next;

  always_comb begin
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    ss_fall     = ss_prev_q & ~ss_s;
    ss_rise     = ~ss_prev_q & ss_s;
    lead_edge   = (sclk_s != sclk_prev_q) && (sclk_prev_q == cpol_l_q);
    trail_edge  = (sclk_s != sclk_prev_q) && (sclk_prev_q != cpol_l_q);
    sample_edge = cpha_l_q ? trail_edge : lead_edge;
    shift_edge  = cpha_l_q ? lead_edge : trail_edge;
    rx_next     = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};
  end

  // ss_n synchronizer resets to the deselected level so reset release never looks like a select.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      sclk_sync_q  <= '0;
      mosi_sync_q  <= '0;
      ss_sync_q    <= '1;
      sclk_prev_q  <= 1'b0;
      ss_prev_q    <= 1'b1;
      cpol_l_q     <= 1'b0;
      cpha_l_q     <= 1'b0;
      first_lead_q <= 1'b0;
      byte_done_q  <= 1'b0;
      bit_cnt_q    <= '0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      tx_buf_q     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
      rx_valid_q  <= 1'b0;

      if (tx_we_i) begin
        tx_buf_q <= tx_data_i;
      end

      case (state_q)
        StIdle: begin
          if (ss_fall) begin
            cpol_l_q     <= cpol_i;
            cpha_l_q     <= cpha_i;
            tx_sr_q      <= tx_buf_q;
            bit_cnt_q    <= '0;
            first_lead_q <= 1'b1;
            byte_done_q  <= 1'b0;
            state_q      <= StShift;
          end
        end

        StShift: begin
          if (ss_rise) begin
            // Deselect wins over any edge seen in the same cycle; partial byte is dropped.
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            byte_done_q  <= 1'b0;
            first_lead_q <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr_q <= rx_next;
              if (bit_cnt_q == LastBit) begin
                rx_data_q   <= rx_next;
                rx_valid_q  <= 1'b1;
                bit_cnt_q   <= '0;
                byte_done_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
              end
            end

            // With cpha=1 the MSB is already on miso, so the frame's first leading edge is a no-op.
            if (shift_edge) begin
              if (cpha_l_q && first_lead_q) begin
                first_lead_q <= 1'b0;
              end else if (byte_done_q) begin
                tx_sr_q     <= tx_buf_q;
                byte_done_q <= 1'b0;
              end else begin
                tx_sr_q <= {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o     = (state_q == StShift);
  assign miso_o     = (state_q == StShift) & tx_sr_q[DATA_WIDTH-1];
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives all four modes,
// multi-byte frames, aborts and async reset, checking against hand-computed bytes.
module tb_spi_slave;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpol;
  logic       cpha;
  logic       ss_n;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_we;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         vcnt = 0;
  logic [7:0] vlog [0:63];

  always #5 clk = ~clk;

  spi_slave #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .cpol_i    (cpol),
    .cpha_i    (cpha),
    .ss_n_i    (ss_n),
    .sclk_i    (sclk),
    .mosi_i    (mosi),
    .miso_o    (miso),
    .tx_data_i (tx_data),
    .tx_we_i   (tx_we),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .busy_o    (busy)
  );

  // Every cycle rx_valid is seen high is logged; a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (rx_valid) begin
      vlog[vcnt % 64] = rx_data;
      vcnt = vcnt + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic half_period(input int we_here, input logic [7:0] we_val);
    if (we_here != 0) begin
      wait_clk(20);
      tx_data = we_val;
      tx_we   = 1'b1;
      wait_clk(1);
      tx_we   = 1'b0;
      wait_clk(HALF - 21);
    end else begin
      wait_clk(HALF);
    end
  endtask

  task automatic load_tx(input logic [7:0] v);
    tx_data = v;
    tx_we   = 1'b1;
    wait_clk(1);
    tx_we   = 1'b0;
    wait_clk(1);
  endtask

  task automatic select(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    mosi = 1'b0;
    wait_clk(10);
    ss_n = 1'b0;
    wait_clk(10);
  endtask

  task automatic deselect();
    wait_clk(HALF);
    ss_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input int we_bit,
                          input logic [7:0] we_val, output logic [7:0] rx);
    rx = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      if (!cpha) begin
        mosi = tx[7-b];
        half_period(int'(b == we_bit), we_val);
        sclk = ~cpol;
        rx[7-b] = miso;
        half_period(0, 8'h00);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = tx[7-b];
        half_period(int'(b == we_bit), we_val);
        sclk = cpol;
        rx[7-b] = miso;
        half_period(0, 8'h00);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clk(3);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data: got %h expected 00", rx_data);
    end
    checks++;
    if ({miso, rx_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got miso/rx_valid/busy=%b expected 000", {miso, rx_valid, busy});
    end
    reset = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_mode0();
    logic [7:0] r;
    int         v0;
    load_tx(8'h3C);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mode0_busy_before: got %b expected 0", busy);
    end
    v0 = vcnt;
    select(1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mode0_busy_selected: got %b expected 1", busy);
    end
    spi_xfer(8'hA5, 8, -1, 8'h00, r);
    deselect();
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL mode0_rx_data: got %h expected a5", rx_data);
    end
    checks++;
    if (vcnt - v0 !== 1 || vlog[v0 % 64] !== 8'hA5) begin
      errors++;
      $display("FAIL mode0_rx_valid: got %0d pulses first %h expected 1 pulse a5",
               vcnt - v0, vlog[v0 % 64]);
    end
    checks++;
    if (r !== 8'h3C) begin
      errors++;
      $display("FAIL mode0_master_rx: got %h expected 3c", r);
    end
    checks++;
    if (busy !== 1'b0 || miso !== 1'b0) begin
      errors++;
      $display("FAIL mode0_idle_after: got busy=%b miso=%b expected 0 0", busy, miso);
    end
  endtask

  task automatic test_modes123();
    logic [7:0] r;
    int         v0;
    load_tx(8'h7E);
    for (int m = 1; m <= 3; m++) begin
      v0 = vcnt;
      select(logic'(m >= 2), logic'(m % 2));
      spi_xfer(8'h81, 8, -1, 8'h00, r);
      deselect();
      checks++;
      if (rx_data !== 8'h81) begin
        errors++;
        $display("FAIL mode%0d_rx_data: got %h expected 81", m, rx_data);
      end
      checks++;
      if (r !== 8'h7E) begin
        errors++;
        $display("FAIL mode%0d_master_rx: got %h expected 7e", m, r);
      end
      checks++;
      if (vcnt - v0 !== 1) begin
        errors++;
        $display("FAIL mode%0d_rx_valid_count: got %0d expected 1", m, vcnt - v0);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0;
    logic [7:0] r1;
    int         v0;
    load_tx(8'h12);
    v0 = vcnt;
    select(1'b0, 1'b0);
    spi_xfer(8'hC3, 8, 5, 8'h34, r0);
    spi_xfer(8'h5A, 8, -1, 8'h00, r1);
    deselect();
    checks++;
    if (vcnt - v0 !== 2) begin
      errors++;
      $display("FAIL b2b_rx_valid_count: got %0d expected 2", vcnt - v0);
    end
    checks++;
    if (vlog[v0 % 64] !== 8'hC3 || vlog[(v0 + 1) % 64] !== 8'h5A) begin
      errors++;
      $display("FAIL b2b_rx_bytes: got %h %h expected c3 5a", vlog[v0 % 64], vlog[(v0 + 1) % 64]);
    end
    checks++;
    if (r0 !== 8'h12 || r1 !== 8'h34) begin
      errors++;
      $display("FAIL b2b_master_rx: got %h %h expected 12 34", r0, r1);
    end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    int         v0;
    load_tx(8'hFF);
    v0 = vcnt;
    select(1'b0, 1'b0);
    spi_xfer(8'h0F, 3, -1, 8'h00, r);
    deselect();
    checks++;
    if (vcnt - v0 !== 0) begin
      errors++;
      $display("FAIL abort_no_valid: got %0d pulses expected 0", vcnt - v0);
    end
    checks++;
    if (rx_data !== 8'h5A) begin
      errors++;
      $display("FAIL abort_rx_hold: got %h expected 5a", rx_data);
    end
    checks++;
    if (miso !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got miso=%b busy=%b expected 0 0", miso, busy);
    end
    select(1'b0, 1'b0);
    spi_xfer(8'hF0, 8, -1, 8'h00, r);
    deselect();
    checks++;
    if (rx_data !== 8'hF0 || r !== 8'hFF) begin
      errors++;
      $display("FAIL abort_next_frame: got rx=%h master=%h expected f0 ff", rx_data, r);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] r;
    int         v0;
    v0 = vcnt;
    select(1'b0, 1'b0);
    spi_xfer(8'h66, 4, -1, 8'h00, r);
    mosi = 1'b0;
    wait_clk(20);
    checks++;
    if (miso !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_midframe_pre: got miso=%b busy=%b expected 1 1", miso, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({miso, rx_valid, busy} !== 3'b000 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_midframe_async: got flags=%b rx=%h expected 000 00",
               {miso, rx_valid, busy}, rx_data);
    end
    ss_n = 1'b1;
    sclk = 1'b0;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(5);
    select(1'b0, 1'b0);
    spi_xfer(8'h99, 8, -1, 8'h00, r);
    deselect();
    checks++;
    if (rx_data !== 8'h99 || r !== 8'h00) begin
      errors++;
      $display("FAIL rst_next_frame: got rx=%h master=%h expected 99 00", rx_data, r);
    end
    checks++;
    if (vcnt - v0 !== 1) begin
      errors++;
      $display("FAIL rst_valid_count: got %0d expected 1", vcnt - v0);
    end
  endtask

  task automatic test_tx_we_midframe();
    logic [7:0] r;
    select(1'b0, 1'b0);
    spi_xfer(8'h0F, 8, 2, 8'hFF, r);
    deselect();
    checks++;
    if (r !== 8'h00 || rx_data !== 8'h0F) begin
      errors++;
      $display("FAIL txwe_current: got master=%h rx=%h expected 00 0f", r, rx_data);
    end
    select(1'b0, 1'b0);
    spi_xfer(8'h55, 8, -1, 8'h00, r);
    deselect();
    checks++;
    if (r !== 8'hFF || rx_data !== 8'h55) begin
      errors++;
      $display("FAIL txwe_next: got master=%h rx=%h expected ff 55", r, rx_data);
    end
  endtask

  initial begin
    reset   = 1'b1;
    cpol    = 1'b0;
    cpha    = 1'b0;
    ss_n    = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    tx_data = 8'h00;
    tx_we   = 1'b0;
    test_reset();
    test_mode0();
    test_modes123();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_tx_we_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
